// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the result display: conversion FSM states, fixed
//   segment glyphs and the digit -> segment decoders. Segments are ordered
//   {g,f,e,d,c,b,a} and are active-low (0 = lit).
//   Optional feature macro used by the importing files: HEX_MODE_EN.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  // Decimal digit glyphs; anything above 9 renders blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Full hexadecimal nibble glyphs (A..F on top of the decimal set).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'hA:    s = SEG_HEX_A;
      4'hB:    s = SEG_HEX_B;
      4'hC:    s = SEG_HEX_C;
      4'hD:    s = SEG_HEX_D;
      4'hE:    s = SEG_HEX_E;
      4'hF:    s = SEG_HEX_F;
      default: s = digit_to_seg(d);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter: 9-bit unsigned binary to 3 BCD
//   digits, one iteration per clock, 9 iterations after start.
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-low reset; aborts a conversion
//   start  in   load bin and begin converting (ignored semantics while running
//               are the caller's responsibility)
//   bin    in   9-bit magnitude to convert
//   done   out  high during the cycle whose clock edge performs the final
//               iteration, so bcd is complete right after that edge
//   bcd    out  {hundreds, tens, ones}
module bin2bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [8:0]  sh_r;
  logic [11:0] bcd_r;
  logic [3:0]  cnt_r;
  logic        run_r;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [11:0] adjust(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      else                     r[i*4 +: 4] = b[i*4 +: 4];
    end
    return r;
  endfunction

  // Shift engine: load on start, then one adjust+shift per clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_r  <= 9'd0;
      bcd_r <= 12'd0;
      cnt_r <= 4'd0;
      run_r <= 1'b0;
    end else if (start) begin
      sh_r  <= bin;
      bcd_r <= 12'd0;
      cnt_r <= 4'd9;
      run_r <= 1'b1;
    end else if (run_r) begin
      bcd_r <= {adjust(bcd_r)[10:0], sh_r[8]};
      sh_r  <= {sh_r[7:0], 1'b0};
      cnt_r <= cnt_r - 4'd1;
      run_r <= (cnt_r != 4'd1);
    end else begin
      run_r <= 1'b0;
    end
  end

  assign done = run_r && (cnt_r == 4'd1);
  assign bcd  = bcd_r;

endmodule

// File: rtl/result_display.sv
// result_display
//   Captures the signed 8-bit ALU result on a strobe, converts it to sign plus
//   three BCD digits and drives a 4-digit multiplexed common-anode display.
//   Optional feature macro: HEX_MODE_EN adds input hex_mode; when set at the
//   sampling edge the value is shown as two raw hex digits instead.
// Ports
//   clock         in   system clock
//   reset         in   asynchronous active-low reset
//   result[7:0]   in   signed two's-complement result
//   result_valid  in   1-cycle capture strobe
//   hex_mode      in   (HEX_MODE_EN only) show raw hex for this capture
//   busy          out  conversion in progress
//   seg[6:0]      out  segments {g,f,e,d,c,b,a}, active-low
//   dp            out  decimal point, active-low, always off
//   an[3:0]       out  digit anodes, active-low one-hot, an[0] rightmost
module result_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] result,
  input  logic       result_valid,
`ifdef HEX_MODE_EN
  input  logic       hex_mode,
`endif
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic [SCAN_W-1:0] CNT_MAX    = SCAN_W'(SCAN_DIV - 1);
  localparam logic [3:0][6:0]   DISP_RESET = {SEG_BLANK, SEG_BLANK, SEG_BLANK, 7'h40};

  state_t          state_r;
  logic            pending_r;
  logic [7:0]      pend_val_r;
  logic            busy_r;
  logic            sign_r;
  logic [3:0][6:0] disp_r;
  logic [3:0][6:0] fmt_s;
  logic [3:0][6:0] dec_s;
  logic [8:0]      mag_s;
  logic            start_s;
  logic            eng_done_s;
  logic [11:0]     eng_bcd_s;
  logic [SCAN_W-1:0] cnt_r;
  logic [1:0]      idx_r;
  logic [1:0]      idx_next_s;
`ifdef HEX_MODE_EN
  logic            pend_hex_r;
  logic            hex_r;
  logic [7:0]      raw_r;
`endif

  // Capture register: a new strobe always overwrites the pending value,
  // and wins over the clear issued when LOAD consumes the previous one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_r  <= 1'b0;
      pend_val_r <= 8'd0;
`ifdef HEX_MODE_EN
      pend_hex_r <= 1'b0;
`endif
    end else if (result_valid) begin
      pending_r  <= 1'b1;
      pend_val_r <= result;
`ifdef HEX_MODE_EN
      pend_hex_r <= hex_mode;
`endif
    end else if (state_r == LOAD) begin
      pending_r  <= 1'b0;
    end else begin
      pending_r  <= pending_r;
    end
  end

  // |result| as 9 bits so that -128 maps to 128.
  assign mag_s = pend_val_r[7] ? (9'd256 - {1'b0, pend_val_r}) : {1'b0, pend_val_r};

`ifdef HEX_MODE_EN
  assign start_s = (state_r == LOAD) && !pend_hex_r;
`else
  assign start_s = (state_r == LOAD);
`endif

  bin2bcd_seq u_bcd (
    .clock (clock),
    .reset (reset),
    .start (start_s),
    .bin   (mag_s),
    .done  (eng_done_s),
    .bcd   (eng_bcd_s)
  );

  // Decimal formatting with leading-zero blanking; ones digit always shown.
  always_comb begin
    dec_s[3] = sign_r ? SEG_MINUS : SEG_BLANK;
    dec_s[2] = (eng_bcd_s[11:8] == 4'd0) ? SEG_BLANK : digit_to_seg(eng_bcd_s[11:8]);
    dec_s[1] = (eng_bcd_s[11:4] == 8'd0) ? SEG_BLANK : digit_to_seg(eng_bcd_s[7:4]);
    dec_s[0] = digit_to_seg(eng_bcd_s[3:0]);
  end

  // Select between decimal and raw-hex presentation.
  always_comb begin
    fmt_s = dec_s;
`ifdef HEX_MODE_EN
    if (hex_r) begin
      fmt_s = {SEG_BLANK, SEG_BLANK, hex_to_seg(raw_r[7:4]), hex_to_seg(raw_r[3:0])};
    end else begin
      fmt_s = dec_s;
    end
`endif
  end

  // Conversion FSM. IDLE also reacts to a strobe on the same edge it is
  // captured, so the display updates 11 clocks after the sampling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      sign_r  <= 1'b0;
      disp_r  <= DISP_RESET;
`ifdef HEX_MODE_EN
      hex_r   <= 1'b0;
      raw_r   <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (pending_r || result_valid) state_r <= LOAD;
          else                           state_r <= IDLE;
        end
        LOAD: begin
          busy_r <= 1'b1;
          sign_r <= pend_val_r[7];
`ifdef HEX_MODE_EN
          hex_r  <= pend_hex_r;
          raw_r  <= pend_val_r;
          if (pend_hex_r) state_r <= DONE;
          else            state_r <= SHIFT;
`else
          state_r <= SHIFT;
`endif
        end
        SHIFT: begin
          if (eng_done_s) state_r <= DONE;
          else            state_r <= SHIFT;
        end
        DONE: begin
          busy_r <= 1'b0;
          disp_r <= fmt_s;
          if (pending_r || result_valid) state_r <= LOAD;
          else                           state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy = busy_r;
  assign dp   = 1'b1;

  // Digit index that the scan registers will present after this edge.
  always_comb begin
    if (cnt_r == CNT_MAX) idx_next_s = idx_r + 2'd1;
    else                  idx_next_s = idx_r;
  end

  // Scan: an and seg are loaded from the same index on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
      an    <= 4'b1110;
      seg   <= 7'h40;
    end else begin
      if (cnt_r == CNT_MAX) cnt_r <= '0;
      else                  cnt_r <= cnt_r + SCAN_W'(1);
      idx_r <= idx_next_s;
      case (idx_next_s)
        2'd0:    an <= 4'b1110;
        2'd1:    an <= 4'b1101;
        2'd2:    an <= 4'b1011;
        2'd3:    an <= 4'b0111;
        default: an <= 4'b1111;
      endcase
      seg <= disp_r[idx_next_s];
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: directed cases plus random captures, checked
// by a scoreboard fed from a reference model of the displayed text.
module tb_result_display;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] MIN = 7'h3F;
`ifdef HEX_MODE_EN
  localparam bit HEX_ON = 1'b1;
`else
  localparam bit HEX_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] result = 8'd0;
  logic       result_valid = 1'b0;
`ifdef HEX_MODE_EN
  logic       hex_mode = 1'b0;
`endif
  logic       busy;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  result_display #(.SCAN_DIV(2), .SCAN_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .result       (result),
    .result_valid (result_valid),
`ifdef HEX_MODE_EN
    .hex_mode     (hex_mode),
`endif
    .busy         (busy),
    .seg          (seg),
    .dp           (dp),
    .an           (an)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [27:0] exp_q[$];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Text the display should show for a capture, {digit3,digit2,digit1,digit0}.
  function automatic logic [27:0] model_disp(input logic [7:0] v, input bit hx);
    int s, m, h, t, o;
    logic [6:0] d3, d2, d1, d0;
    if (hx) return {BLK, BLK, GLYPH[v[7:4]], GLYPH[v[3:0]]};
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    d3 = (s < 0) ? MIN : BLK;
    d2 = (h == 0) ? BLK : GLYPH[h];
    d1 = (h == 0 && t == 0) ? BLK : GLYPH[t];
    d0 = GLYPH[o];
    return {d3, d2, d1, d0};
  endfunction

  // One full refresh cycle (4 slots x 2 clocks) reassembled from an/seg.
  task automatic capture_frame(output logic [27:0] f, output bit ok);
    bit seen [4];
    f = '1;
    ok = 1'b1;
    seen = '{default: 1'b0};
    for (int s = 0; s < 8; s++) begin
      @(negedge clock);
      case (an)
        4'b1110: begin f[6:0]   = seg; seen[0] = 1'b1; end
        4'b1101: begin f[13:7]  = seg; seen[1] = 1'b1; end
        4'b1011: begin f[20:14] = seg; seen[2] = 1'b1; end
        4'b0111: begin f[27:21] = seg; seen[3] = 1'b1; end
        default: ok = 1'b0;
      endcase
    end
    ok = ok && seen[0] && seen[1] && seen[2] && seen[3];
  endtask

  task automatic strobe(input logic [7:0] v, input bit hx);
    @(negedge clock);
    result = v;
`ifdef HEX_MODE_EN
    hex_mode = hx;
`endif
    result_valid = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] v, input bit hx);
    exp_q.push_back(model_disp(v, hx));
    strobe(v, hx);
    repeat (30) @(negedge clock);
  endtask

  // Monitor: a falling busy marks a display update; read the next frame.
  initial begin : monitor
    logic        prev_busy;
    logic [27:0] got;
    logic [27:0] want;
    bit          ok;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en && prev_busy && !busy) begin
        capture_frame(got, ok);
        check("scan_onehot", 32'(ok), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_update", 32'(got), 32'h0);
        end else begin
          want = exp_q.pop_front();
          check("display", 32'(got), 32'(want));
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [27:0] f;
    bit          ok;
    int          rise, fall;
    int          hi;
    logic [7:0]  v, last_v;
    bit          hx, last_hx;
    int          extras;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_an", 32'(an), 32'h0E);
    check("rst_seg", 32'(seg), 32'h40);
    check("rst_dp", 32'(dp), 32'd1);

    // Scan after release: slot advances every 2 clocks, display "   0"
    reset = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clock);
      check("scan_an", 32'(an), 32'(~(4'b0001 << ((j / 2) % 4)) & 4'hF));
      check("scan_seg", 32'(seg), ((j / 2) % 4 == 0) ? 32'h40 : 32'h7F);
    end

    mon_en = 1'b1;

    // 127 with latency: busy rises 1 clock and falls 11 clocks after sampling
    exp_q.push_back(model_disp(8'd127, 1'b0));
    strobe(8'd127, 1'b0);
    rise = -1;
    fall = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (busy && rise < 0) rise = k;
      if (!busy && rise >= 0 && fall < 0) fall = k;
    end
    check("lat_busy_rise", 32'(rise), 32'd1);
    check("lat_busy_fall", 32'(fall), 32'd11);
    repeat (20) @(negedge clock);

    send(8'h80, 1'b0);
    send(8'hFB, 1'b0);
    send(8'h00, 1'b0);

    // Last write wins while busy: 10 shown, 20 dropped, 30 shown
    exp_q.push_back(model_disp(8'd10, 1'b0));
    exp_q.push_back(model_disp(8'd30, 1'b0));
    strobe(8'd10, 1'b0);
    repeat (2) @(negedge clock);
    strobe(8'd20, 1'b0);
    repeat (2) @(negedge clock);
    strobe(8'd30, 1'b0);
    repeat (40) @(negedge clock);

    if (HEX_ON) send(8'hA5, 1'b1);
    send(8'hA5, 1'b0);

    check("queue_drained_pre_reset", 32'(exp_q.size()), 32'd0);

    // Reset during the 4th shift of 99: abort, display back to "   0"
    mon_en = 1'b0;
    strobe(8'd99, 1'b0);
    repeat (5) @(negedge clock);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(an), 32'h0E);
    check("abort_seg", 32'(seg), 32'h40);
    @(negedge clock);
    reset = 1'b1;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (busy) hi++;
    end
    check("abort_no_resume", 32'(hi), 32'd0);
    capture_frame(f, ok);
    check("abort_frame_ok", 32'(ok), 32'd1);
    check("abort_display", 32'(f), 32'(model_disp(8'd0, 1'b0)));
    mon_en = 1'b1;
    repeat (2) @(negedge clock);

    // Random captures, some followed by overwrites while converting
    for (int g = 0; g < 25; g++) begin
      v  = 8'($urandom_range(0, 255));
      hx = HEX_ON ? 1'($urandom_range(0, 1)) : 1'b0;
      extras = hx ? 0 : int'($urandom_range(0, 2));
      exp_q.push_back(model_disp(v, hx));
      strobe(v, hx);
      last_v = v;
      last_hx = hx;
      for (int e = 0; e < extras; e++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        last_v  = 8'($urandom_range(0, 255));
        last_hx = HEX_ON ? 1'($urandom_range(0, 1)) : 1'b0;
        strobe(last_v, last_hx);
      end
      if (extras > 0) exp_q.push_back(model_disp(last_v, last_hx));
      repeat (40) @(negedge clock);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
